// File: rtl/password_cracker_main.sv
// Dictionary-attack engine: SHA-256 hashes each newline-terminated password from the
// preloaded byte memory and stops at the first digest equal to `hash` or at the 0x05 end marker.
module password_cracker_main #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned MAX_PW_LEN = 55
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [255:0] hash,
  output logic [31:0]  password_count,
  output logic         cracked,
  output logic         done
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [7:0] END_OF_LIST = 8'h05;
  localparam logic [7:0] END_OF_PW   = 8'h0A;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    IDLE, LOAD, PAD, HASH, FINAL, COMPARE, DONE
  } state_t;

  // Word list, preloaded from outside; never written by this block.
  logic [7:0] byte_addressable_memory [0:MEM_DEPTH-1];

  state_t           state;
  logic             init_q;
  logic [PW-1:0]    ptr;
  logic [5:0]       len;
  logic [5:0]       round;
  logic [511:0]     msg;
  logic [0:7][31:0] wv;
  logic [0:7][31:0] digest;

  logic             init_rise;
  logic [7:0]       cur_byte;
  logic [31:0]      t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign init_rise = init & ~init_q;

  // Reads past the end of memory behave as an end-of-list marker.
  always_comb begin
    cur_byte = END_OF_LIST;
    if (ptr < PW'(MEM_DEPTH)) cur_byte = byte_addressable_memory[ptr[AW-1:0]];
  end

  // One compression round; msg[511:480] is always W[t] of the sliding schedule window.
  always_comb begin
    t1 = wv[7]
       + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
       + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
       + K[round]
       + msg[511:480];
    t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
       + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    w_new = (rotr(msg[63:32], 17) ^ rotr(msg[63:32], 19) ^ (msg[63:32] >> 10))
          + msg[223:192]
          + (rotr(msg[479:448], 7) ^ rotr(msg[479:448], 18) ^ (msg[479:448] >> 3))
          + msg[511:480];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      init_q         <= 1'b0;
      ptr            <= '0;
      len            <= '0;
      round          <= '0;
      msg            <= '0;
      wv             <= '0;
      digest         <= '0;
      password_count <= '0;
      cracked        <= 1'b0;
      done           <= 1'b0;
    end else begin
      init_q <= init;
      case (state)
        IDLE, DONE: begin
          if (init_rise) begin
            password_count <= '0;
            cracked        <= 1'b0;
            done           <= 1'b0;
            ptr            <= '0;
            len            <= '0;
            msg            <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          ptr <= ptr + PW'(1);
          if (cur_byte == END_OF_LIST) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (cur_byte == END_OF_PW) begin
            state <= PAD;
          end else if (len < 6'(MAX_PW_LEN)) begin
            msg[{~len, 3'b111} -: 8] <= cur_byte;
            len                      <= len + 6'd1;
          end
        end
        PAD: begin
          msg[{~len, 3'b111} -: 8] <= 8'h80;
          msg[63:0]                <= 64'({len, 3'b000});
          wv                       <= IV;
          round                    <= '0;
          state                    <= HASH;
        end
        HASH: begin
          wv    <= {t1 + t2, wv[0], wv[1], wv[2], wv[3] + t1, wv[4], wv[5], wv[6]};
          msg   <= {msg[479:0], w_new};
          round <= round + 6'd1;
          if (round == 6'd63) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) digest[i] <= IV[i] + wv[i];
          password_count <= password_count + 32'd1;
          state          <= COMPARE;
        end
        COMPARE: begin
          if (digest == hash) begin
            cracked <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            len   <= '0;
            msg   <= '0;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_password_cracker_main.sv
// Directed bench for password_cracker_main: table of memory images and target digests
// with hand-derived counts and latencies, plus retrigger and mid-scan reset sequences.
module tb_password_cracker_main;

  localparam int unsigned LIMIT = 6000;

  localparam logic [255:0] H_DEF   = 256'hcb8379ac2098aa165029e3938a51da0bcecfc008fd6795f401178647f96c5b34;
  localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] H_MISS  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ac;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         init = 1'b0;
  logic [255:0] hash = '0;
  logic [31:0]  password_count;
  logic         cracked;
  logic         done;

  int n_vec = 0;
  int n_miss = 0;

  password_cracker_main dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .hash          (hash),
    .password_count(password_count),
    .cracked       (cracked),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           sel;
    logic [255:0] h;
    int           cnt;
    bit           cr;
    int           lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 0: "def\nabc\nabc\n" 05; 1: 05; 2: "\n" 05; 3: "ab" 05; 4: "abc\n" filling all of memory
  task automatic load_mem(input int sel);
    string s;
    for (int i = 0; i < 256; i++) dut.byte_addressable_memory[i] = 8'h05;
    case (sel)
      0: s = "def\nabc\nabc\n";
      2: s = "\n";
      3: s = "ab";
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) dut.byte_addressable_memory[i] = s[i];
    if (sel == 4) begin
      s = "abc\n";
      for (int i = 0; i < 256; i++) dut.byte_addressable_memory[i] = s[i % 4];
    end
  endtask

  task automatic do_reset(input int sel);
    reset = 1'b0;
    init  = 1'b0;
    load_mem(sel);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({password_count, cracked, done}), 64'd0);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic launch(input logic [255:0] h);
    hash = h;
    @(negedge clk) init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cnt, input bit cr, input int lat, input int cyc);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cracked"}, 64'(cracked), 64'(cr));
    check({tag, "_count"}, 64'(password_count), 64'(cnt));
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
  endtask

  initial begin
    int cyc;

    vecs[0] = '{sel: 0, h: H_DEF,   cnt: 1,  cr: 1'b1, lat: 71};
    vecs[1] = '{sel: 0, h: H_ABC,   cnt: 2,  cr: 1'b1, lat: 142};
    vecs[2] = '{sel: 0, h: H_MISS,  cnt: 3,  cr: 1'b0, lat: 214};
    vecs[3] = '{sel: 1, h: H_ABC,   cnt: 0,  cr: 1'b0, lat: 1};
    vecs[4] = '{sel: 2, h: H_EMPTY, cnt: 1,  cr: 1'b1, lat: 68};
    vecs[5] = '{sel: 3, h: H_ABC,   cnt: 0,  cr: 1'b0, lat: 3};
    vecs[6] = '{sel: 4, h: H_ABC,   cnt: 1,  cr: 1'b1, lat: 71};
    vecs[7] = '{sel: 4, h: H_MISS,  cnt: 64, cr: 1'b0, lat: 4545};
    vecs[8] = '{sel: 2, h: H_ABC,   cnt: 1,  cr: 1'b0, lat: 69};

    #3;
    for (int v = 0; v < 9; v++) begin
      do_reset(vecs[v].sel);
      launch(vecs[v].h);
      wait_done(cyc);
      check_result($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].cr, vecs[v].lat, cyc);
    end

    // init held high must not retrigger; a fresh edge restarts and clears
    do_reset(0);
    hash = H_DEF;
    @(negedge clk) init = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc);
    check_result("held", 1, 1'b1, 71, cyc);
    repeat (10) @(posedge clk);
    #1;
    check("held_hold", 64'({password_count, cracked, done}), 64'({32'd1, 1'b1, 1'b1}));
    @(negedge clk) init = 1'b0;
    @(negedge clk) init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    check("restart_clear", 64'({password_count, cracked, done}), 64'd0);
    wait_done(cyc);
    check_result("restart", 1, 1'b1, 71, cyc);

    // init pulse while busy is ignored
    do_reset(0);
    launch(H_ABC);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      init = (cyc == 30) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    init = 1'b0;
    check_result("busy_init", 2, 1'b1, 142, cyc);

    // asynchronous reset during HASH of the second password
    do_reset(0);
    launch(H_ABC);
    repeat (91) @(posedge clk);
    #1;
    check("pre_reset_count", 64'(password_count), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset", 64'({password_count, cracked, done}), 64'd0);
    @(negedge clk) reset = 1'b1;
    launch(H_DEF);
    wait_done(cyc);
    check_result("after_reset", 1, 1'b1, 71, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
